// File: rtl/wam_round_ctrl.sv
// Whack-a-mole round controller: synchronises the player controls, sequences
// the round (IDLE/ARM/PLAY/PAUSED/OVER) and counts down the round seconds.
module wam_round_ctrl #(
    parameter int unsigned CLK_HZ    = 50000000,
    parameter int unsigned ROUND_SEC = 30
) (
    input  logic       clk,
    input  logic       clr,
    input  logic       btn_start,
    input  logic       btn_pause,
    input  logic [1:0] sw_diff,
    output logic       start,
    output logic       pause,
    output logic [3:0] difficulty,
    output logic [7:0] time_left,
    output logic       game_over
);

    localparam int unsigned TICK_W = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam logic [TICK_W-1:0] TICK_MAX  = TICK_W'(CLK_HZ - 1);
    localparam logic [7:0]        ROUND_LEN = 8'(ROUND_SEC);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        ARM    = 3'd1,
        PLAY   = 3'd2,
        PAUSED = 3'd3,
        OVER   = 3'd4
    } state_t;

    state_t state, state_n;

    logic              start_s1, start_s2, start_prev, start_edge_q;
    logic              pause_s1, pause_s2, pause_prev, pause_edge_q;
    logic [1:0]        diff_s1, diff_s2;
    logic [TICK_W-1:0] tick, tick_n;
    logic [7:0]        time_left_n;
    logic [3:0]        difficulty_n;
    logic              expire;

    // Two-flop synchronisers plus registered rising-edge detect on the buttons
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            start_s1     <= 1'b0;
            start_s2     <= 1'b0;
            start_prev   <= 1'b0;
            start_edge_q <= 1'b0;
            pause_s1     <= 1'b0;
            pause_s2     <= 1'b0;
            pause_prev   <= 1'b0;
            pause_edge_q <= 1'b0;
            diff_s1      <= 2'b00;
            diff_s2      <= 2'b00;
        end else begin
            start_s1     <= btn_start;
            start_s2     <= start_s1;
            start_prev   <= start_s2;
            start_edge_q <= start_s2 & ~start_prev;
            pause_s1     <= btn_pause;
            pause_s2     <= pause_s1;
            pause_prev   <= pause_s2;
            pause_edge_q <= pause_s2 & ~pause_prev;
            diff_s1      <= sw_diff;
            diff_s2      <= diff_s1;
        end
    end

    // State, timer and registered outputs (outputs follow the next state)
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state      <= IDLE;
            tick       <= '0;
            time_left  <= 8'd0;
            difficulty <= 4'b0001;
            start      <= 1'b0;
            pause      <= 1'b1;
            game_over  <= 1'b0;
        end else begin
            state      <= state_n;
            tick       <= tick_n;
            time_left  <= time_left_n;
            difficulty <= difficulty_n;
            start      <= (state_n == ARM);
            pause      <= (state_n == IDLE) || (state_n == PAUSED) || (state_n == OVER);
            game_over  <= (state_n == OVER);
        end
    end

    // Next-state and timer update; start edge overrides everything
    always_comb begin
        state_n      = state;
        tick_n       = tick;
        time_left_n  = time_left;
        difficulty_n = difficulty;
        expire       = 1'b0;

        if (start_edge_q) begin
            state_n      = ARM;
            tick_n       = '0;
            time_left_n  = ROUND_LEN;
            difficulty_n = 4'b0001 << diff_s2;
        end else begin
            case (state)
                ARM: state_n = PLAY;
                PLAY: begin
                    if (tick == TICK_MAX) begin
                        tick_n = '0;
                        if (time_left != 8'd0) begin
                            time_left_n = time_left - 8'd1;
                        end
                        expire = (time_left <= 8'd1);
                    end else begin
                        tick_n = tick + TICK_W'(1);
                    end
                    // Expiry beats a coincident pause edge
                    if (expire) begin
                        state_n = OVER;
                    end else if (pause_edge_q) begin
                        state_n = PAUSED;
                    end
                end
                PAUSED: begin
                    if (pause_edge_q) begin
                        state_n = PLAY;
                    end
                end
                IDLE:    state_n = IDLE;
                OVER:    state_n = OVER;
                default: state_n = IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_wam_round_ctrl.sv
// Scoreboard bench for wam_round_ctrl (CLK_HZ=10, ROUND_SEC=3): stimulus pushes
// expected output snapshots with their cycle numbers; the monitor pops and
// compares one entry each time the DUT outputs change or start is high.
module tb_wam_round_ctrl;

    logic       clk = 1'b0;
    logic       clr;
    logic       btn_start;
    logic       btn_pause;
    logic [1:0] sw_diff;
    logic       start;
    logic       pause;
    logic [3:0] difficulty;
    logic [7:0] time_left;
    logic       game_over;

    wam_round_ctrl #(.CLK_HZ(10), .ROUND_SEC(3)) dut (
        .clk        (clk),
        .clr        (clr),
        .btn_start  (btn_start),
        .btn_pause  (btn_pause),
        .sw_diff    (sw_diff),
        .start      (start),
        .pause      (pause),
        .difficulty (difficulty),
        .time_left  (time_left),
        .game_over  (game_over)
    );

    always #5 clk = ~clk;

    typedef struct {
        int unsigned cyc;
        logic        st;
        logic        pa;
        logic [3:0]  df;
        logic [7:0]  tl;
        logic        go;
    } exp_t;

    exp_t        exp_q[$];
    int unsigned cyc = 0;
    int          n_checks = 0;
    int          n_fail = 0;
    logic [14:0] last_snap = '0;
    logic [14:0] snap;

    assign snap = {start, pause, difficulty, time_left, game_over};

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void push(input int unsigned c, input logic st, input logic pa,
                                 input logic [3:0] df, input logic [7:0] tl, input logic go);
        exp_t e;
        e.cyc = c; e.st = st; e.pa = pa; e.df = df; e.tl = tl; e.go = go;
        exp_q.push_back(e);
    endfunction

    // Monitor: compare every output change (and every start cycle) against the queue
    always @(negedge clk) begin
        exp_t e;
        if (clr) begin
            last_snap = snap;
        end else if (snap != last_snap || start) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_event cyc=%0d got st=%b pa=%b df=%b tl=%0d go=%b",
                         cyc, start, pause, difficulty, time_left, game_over);
            end else begin
                e = exp_q.pop_front();
                if (e.cyc != cyc || e.st != start || e.pa != pause || e.df != difficulty ||
                    e.tl != time_left || e.go != game_over) begin
                    n_fail++;
                    $display("FAIL event got cyc=%0d st=%b pa=%b df=%b tl=%0d go=%b want cyc=%0d st=%b pa=%b df=%b tl=%0d go=%b",
                             cyc, start, pause, difficulty, time_left, game_over,
                             e.cyc, e.st, e.pa, e.df, e.tl, e.go);
                end
            end
            last_snap = snap;
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic check_reset(input string name);
        n_checks++;
        if (snap != {1'b0, 1'b1, 4'b0001, 8'd0, 1'b0}) begin
            n_fail++;
            $display("FAIL %s got st=%b pa=%b df=%b tl=%0d go=%b want st=0 pa=1 df=0001 tl=0 go=0",
                     name, start, pause, difficulty, time_left, game_over);
        end
    endtask

    initial begin
        int unsigned b;
        clr = 1'b1; btn_start = 1'b0; btn_pause = 1'b0; sw_diff = 2'b00;
        step(3);
        check_reset("reset_power_on");
        clr = 1'b0;
        step(5);

        // Full round, no pause, difficulty 10 -> 0100; pause ignored in OVER
        sw_diff = 2'b10; btn_start = 1'b1; b = cyc;
        push(b + 4,  1'b1, 1'b0, 4'b0100, 8'd3, 1'b0);
        push(b + 5,  1'b0, 1'b0, 4'b0100, 8'd3, 1'b0);
        push(b + 15, 1'b0, 1'b0, 4'b0100, 8'd2, 1'b0);
        push(b + 25, 1'b0, 1'b0, 4'b0100, 8'd1, 1'b0);
        push(b + 35, 1'b0, 1'b1, 4'b0100, 8'd0, 1'b1);
        step(6);  btn_start = 1'b0;
        step(45); btn_pause = 1'b1;
        step(5);  btn_pause = 1'b0;
        step(5);

        // Pause at time_left=2 for 50 cycles, then resume
        btn_start = 1'b1; b = cyc;
        push(b + 4,  1'b1, 1'b0, 4'b0100, 8'd3, 1'b0);
        push(b + 5,  1'b0, 1'b0, 4'b0100, 8'd3, 1'b0);
        push(b + 15, 1'b0, 1'b0, 4'b0100, 8'd2, 1'b0);
        push(b + 21, 1'b0, 1'b1, 4'b0100, 8'd2, 1'b0);
        push(b + 71, 1'b0, 1'b0, 4'b0100, 8'd2, 1'b0);
        push(b + 75, 1'b0, 1'b0, 4'b0100, 8'd1, 1'b0);
        push(b + 85, 1'b0, 1'b1, 4'b0100, 8'd0, 1'b1);
        step(6);  btn_start = 1'b0;
        step(11); btn_pause = 1'b1;
        step(10); btn_pause = 1'b0;
        step(40); btn_pause = 1'b1;
        step(5);  btn_pause = 1'b0;
        step(20);

        // Start and pause edges together in PLAY: restart wins, no PAUSED
        btn_start = 1'b1; b = cyc;
        push(b + 4,  1'b1, 1'b0, 4'b0100, 8'd3, 1'b0);
        push(b + 5,  1'b0, 1'b0, 4'b0100, 8'd3, 1'b0);
        push(b + 15, 1'b0, 1'b0, 4'b0100, 8'd2, 1'b0);
        push(b + 18, 1'b1, 1'b0, 4'b1000, 8'd3, 1'b0);
        push(b + 19, 1'b0, 1'b0, 4'b1000, 8'd3, 1'b0);
        push(b + 29, 1'b0, 1'b0, 4'b1000, 8'd2, 1'b0);
        push(b + 39, 1'b0, 1'b0, 4'b1000, 8'd1, 1'b0);
        push(b + 49, 1'b0, 1'b1, 4'b1000, 8'd0, 1'b1);
        step(6); btn_start = 1'b0;
        step(8); btn_start = 1'b1; btn_pause = 1'b1; sw_diff = 2'b11;
        step(6); btn_start = 1'b0; btn_pause = 1'b0;
        step(35);

        // Pause edge on the final tick: expiry wins
        btn_start = 1'b1; b = cyc;
        push(b + 4,  1'b1, 1'b0, 4'b1000, 8'd3, 1'b0);
        push(b + 5,  1'b0, 1'b0, 4'b1000, 8'd3, 1'b0);
        push(b + 15, 1'b0, 1'b0, 4'b1000, 8'd2, 1'b0);
        push(b + 25, 1'b0, 1'b0, 4'b1000, 8'd1, 1'b0);
        push(b + 35, 1'b0, 1'b1, 4'b1000, 8'd0, 1'b1);
        step(6);  btn_start = 1'b0;
        step(25); btn_pause = 1'b1;
        step(6);  btn_pause = 1'b0;
        step(10);

        // clr mid-PLAY at time_left=2, then pause edges leave it in IDLE
        sw_diff = 2'b01; btn_start = 1'b1; b = cyc;
        push(b + 4,  1'b1, 1'b0, 4'b0010, 8'd3, 1'b0);
        push(b + 5,  1'b0, 1'b0, 4'b0010, 8'd3, 1'b0);
        push(b + 15, 1'b0, 1'b0, 4'b0010, 8'd2, 1'b0);
        step(6);  btn_start = 1'b0;
        step(11); clr = 1'b1;
        #1;
        check_reset("clr_mid_play");
        step(2);  clr = 1'b0;
        step(3);  btn_pause = 1'b1;
        step(5);  btn_pause = 1'b0;
        step(5);  btn_pause = 1'b1;
        step(5);  btn_pause = 1'b0;
        step(10);
        check_reset("idle_after_clr");

        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL missing_events got %0d left in queue want 0", exp_q.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/wam_round_ctrl.md
WAM_ROUND_CTRL -- requirements
Module: wam_round_ctrl

Interface
REQ-001 SHALL have parameter CLK_HZ, default 50000000, meaning clk cycles per one-second timer tick.
REQ-002 SHALL have parameter ROUND_SEC, default 30, meaning round length in seconds (1..255).
REQ-003 SHALL have port clk  input  1  system clock (50 MHz); sole clock.
REQ-004 SHALL have port clr  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port btn_start  input  1  raw start button, level, asynchronous to clk.
REQ-006 SHALL have port btn_pause  input  1  raw pause button, level, asynchronous to clk.
REQ-007 SHALL have port sw_diff  input  2  difficulty switches, asynchronous to clk.
REQ-008 SHALL have port start  output  1  one-cycle round-start pulse to the game logic.
REQ-009 SHALL have port pause  output  1  freeze level to the game logic.
REQ-010 SHALL have port difficulty  output  4  difficulty code to the game logic.
REQ-011 SHALL have port time_left  output  8  remaining round seconds, binary.
REQ-012 SHALL have port game_over  output  1  high while the round has expired.

Function
REQ-013 SHALL pass btn_start, btn_pause and sw_diff each through a 2-flop synchroniser; button edge = synchronised high AND previous synchronised low.
REQ-014 SHALL implement FSM states IDLE, ARM, PLAY, PAUSED, OVER; all outputs registered.
REQ-015 SHALL go from any state to ARM on a start edge; start edge has priority over every other event in the same cycle.
REQ-016 SHALL stay in ARM exactly one cycle, then enter PLAY; start = 1 only during the ARM cycle.
REQ-017 SHALL, with btn_start rising before clk edge k, sample the start edge at edge k+2, drive start high for the cycle after edge k+3, and drop it after edge k+4.
REQ-018 SHALL latch difficulty in ARM from synchronised sw_diff: 00->4'b0001, 01->4'b0010, 10->4'b0100, 11->4'b1000; hold it until the next ARM.
REQ-019 SHALL in ARM load time_left = ROUND_SEC and clear the tick counter.
REQ-020 SHALL in PLAY increment the tick counter each cycle; on reaching CLK_HZ-1, wrap to 0 and decrement time_left by 1.
REQ-021 SHALL enter OVER on the cycle a decrement makes time_left 0; time_left never wraps below 0.
REQ-022 SHALL toggle PLAY<->PAUSED on a pause edge; in PAUSED hold tick counter and time_left unchanged.
REQ-023 SHALL ignore pause edges in IDLE, ARM and OVER.
REQ-024 SHALL, when expiry and a pause edge coincide in PLAY, enter OVER (expiry wins).
REQ-025 SHALL drive pause = 1 in IDLE, PAUSED and OVER, and 0 in ARM and PLAY.
REQ-026 SHALL drive game_over = 1 only in OVER; OVER holds until a start edge or clr.
REQ-027 SHALL size the tick counter to ceil(log2(CLK_HZ)) bits.

Reset
REQ-028 SHALL on clr asynchronously force state IDLE, start 0, pause 1, difficulty 4'b0001, time_left 0, game_over 0, tick counter 0, synchroniser and edge flops 0.
REQ-029 SHALL, on clr asserted mid-round, abort the round immediately; after release, remain in IDLE until a new start edge.
REQ-030 SHALL release clr so the first state change occurs only on a clk edge after deassertion.

Verification (bench uses CLK_HZ=10, ROUND_SEC=3)
REQ-031 SHALL cover: clr pulse, then btn_start high with sw_diff=10 -> start high for exactly 1 cycle 3 edges after input; difficulty=4'b0100; time_left=3; pause=0.
REQ-032 SHALL cover: full round with no pause -> time_left 3->2->1->0 at 10-cycle intervals; game_over=1 and pause=1 in the same cycle time_left reaches 0.
REQ-033 SHALL cover: pause edge at time_left=2, hold 50 cycles, second pause edge -> time_left stays 2 while paused; next decrement occurs exactly the remaining tick count after resume.
REQ-034 SHALL cover: start and pause edges in the same cycle during PLAY -> ARM entered, time_left reloaded to 3, no PAUSED entry.
REQ-035 SHALL cover: pause edge coinciding with final tick -> state OVER, game_over=1, time_left=0.
REQ-036 SHALL cover: clr asserted mid-PLAY at time_left=2 -> outputs immediately at reset values; pause edges after release leave state IDLE.
